// File: rtl/clk_div_multi_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   mode_e            : per-channel output mode (toggle / pulse)
//   DIV_RESET_DEFAULT : divisor loaded into every channel at reset
//   clog2()           : select-width helper, never returns less than 1
package clk_div_multi_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int unsigned DIV_RESET_DEFAULT = 49999;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) w++;
        return w;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: down-counter, active/pending divisor and registered
// out/tick generation.
//   iCLK, iRST_N : clock, async active-low reset
//   en, mode     : run enable, output mode (0 toggle, 1 pulse)
//   sync         : restart strobe shared by all channels
//   wr, wr_div   : decoded divisor write and its value
//   out, tick    : generated clock/strobe, terminal-count strobe
//   pending      : a written divisor is waiting to be applied
module clk_div_chan
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned               COUNTER_WIDTH = 16,
    parameter logic [COUNTER_WIDTH-1:0]  DIV_RESET     = COUNTER_WIDTH'(DIV_RESET_DEFAULT)
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic                     en,
    input  logic                     mode,
    input  logic                     sync,
    input  logic                     wr,
    input  logic [COUNTER_WIDTH-1:0] wr_div,
    output logic                     out,
    output logic                     tick,
    output logic                     pending
);

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] div_act_q, div_act_d;
    logic [COUNTER_WIDTH-1:0] div_pend_q, div_pend_d;
    logic                     pend_v_q, pend_v_d;
    logic                     out_q, out_d;
    logic                     tick_q, tick_d;
    logic                     term;
    logic                     reload;
    logic [COUNTER_WIDTH-1:0] reload_div;
    mode_e                    mode_sel;

    always_comb begin
        mode_sel   = mode_e'(mode);
        term       = en && (cnt_q == '0) && !sync;
        // Disable, sync and terminal count all restart the period and are
        // the only points where a pending divisor becomes active.
        reload     = !en || sync || term;
        reload_div = pend_v_q ? div_pend_q : div_act_q;

        cnt_d      = cnt_q - COUNTER_WIDTH'(1);
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_v_d   = pend_v_q;

        if (reload) begin
            cnt_d     = reload_div;
            div_act_d = reload_div;
            pend_v_d  = 1'b0;
        end

        // A write in a reload cycle lands behind the divisor being applied.
        if (wr) begin
            div_pend_d = wr_div;
            pend_v_d   = 1'b1;
        end

        tick_d = term;
        if (!en || sync) begin
            out_d = 1'b0;
        end else if (mode_sel == MODE_PULSE) begin
            out_d = term;
        end else begin
            out_d = out_q ^ term;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q      <= DIV_RESET;
            div_act_q  <= DIV_RESET;
            div_pend_q <= '0;
            pend_v_q   <= 1'b0;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_v_q   <= pend_v_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
        end
    end

    assign out     = out_q;
    assign tick    = tick_q;
    assign pending = pend_v_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock / clock-enable generator.
//   iCLK, iRST_N       : clock, async active-low reset
//   en, mode [NUM_CH]  : per-channel enable and mode (0 toggle, 1 pulse)
//   sync               : restarts every channel in phase
//   wr_en/wr_ch/wr_div : divisor write; wr_ch >= NUM_CH is ignored
//   out, tick, pending : per-channel generated clock, terminal strobe,
//                        write-waiting flag
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned               NUM_CH        = 4,
    parameter int unsigned               COUNTER_WIDTH = 16,
    parameter logic [COUNTER_WIDTH-1:0]  DIV_RESET     = COUNTER_WIDTH'(DIV_RESET_DEFAULT)
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    input  logic [NUM_CH-1:0]          en,
    input  logic [NUM_CH-1:0]          mode,
    input  logic                       sync,
    input  logic                       wr_en,
    input  logic [clog2(NUM_CH)-1:0]   wr_ch,
    input  logic [COUNTER_WIDTH-1:0]   wr_div,
    output logic [NUM_CH-1:0]          out,
    output logic [NUM_CH-1:0]          tick,
    output logic [NUM_CH-1:0]          pending
);

    localparam int unsigned CH_W = clog2(NUM_CH);

    logic [NUM_CH-1:0] wr_sel;

    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_en && (wr_ch == CH_W'(i))) wr_sel[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .DIV_RESET     (DIV_RESET)
        ) u_chan (
            .iCLK    (iCLK),
            .iRST_N  (iRST_N),
            .en      (en[g]),
            .mode    (mode[g]),
            .sync    (sync),
            .wr      (wr_sel[g]),
            .wr_div  (wr_div),
            .out     (out[g]),
            .tick    (tick[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DRST = 3;

    logic           iCLK = 1'b0;
    logic           iRST_N = 1'b0;
    logic [NCH-1:0] en = '0;
    logic [NCH-1:0] mode = '0;
    logic           sync = 1'b0;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_ch = '0;
    logic [CW-1:0]  wr_div = '0;
    logic [NCH-1:0] out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;

    always #5 iCLK = ~iCLK;

    clk_div_multi #(
        .NUM_CH        (NCH),
        .COUNTER_WIDTH (CW),
        .DIV_RESET     (8'd3)
    ) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .en      (en),
        .mode    (mode),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .out     (out),
        .tick    (tick),
        .pending (pending)
    );

    // Stimulus intent, copied onto the DUT pins just after a falling edge.
    logic [NCH-1:0] s_en = '0;
    logic [NCH-1:0] s_mode = '0;
    logic           s_sync = 1'b0;
    logic           s_wr_en = 1'b0;
    logic [1:0]     s_wr_ch = '0;
    logic [CW-1:0]  s_wr_div = '0;

    typedef struct {
        logic [NCH-1:0] out;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] pending;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    bit mon_en = 0;

    // Reference model: each channel measures elapsed cycles since its period
    // started; the terminal count is the cycle where elapsed == period.
    int m_age[NCH];
    int m_per[NCH];
    int m_next[NCH];
    bit m_has_next[NCH];
    bit m_out[NCH];
    bit m_tick[NCH];

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_age[i] = 0; m_per[i] = DRST; m_next[i] = 0;
            m_has_next[i] = 0; m_out[i] = 0; m_tick[i] = 0;
        end
    endfunction

    function automatic void model_step_and_push();
        exp_t e;
        for (int i = 0; i < NCH; i++) begin
            bit hit;
            hit = en[i] && !sync && (m_age[i] == m_per[i]);
            m_tick[i] = hit;
            if (!en[i] || sync) m_out[i] = 0;
            else if (mode[i])   m_out[i] = hit;
            else                m_out[i] = m_out[i] ^ hit;
            if (!en[i] || sync || hit) begin
                if (m_has_next[i]) begin
                    m_per[i] = m_next[i];
                    m_has_next[i] = 0;
                end
                m_age[i] = 0;
            end else begin
                m_age[i] = m_age[i] + 1;
            end
            if (wr_en && int'(wr_ch) == i) begin
                m_next[i] = int'(wr_div);
                m_has_next[i] = 1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            e.out[i] = m_out[i];
            e.tick[i] = m_tick[i];
            e.pending[i] = m_has_next[i];
        end
        exp_q.push_back(e);
    endfunction

    function automatic void chk(string nm, logic [NCH-1:0] act, logic [NCH-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endfunction

    // Monitor: one expected record per rising edge while enabled.
    always @(posedge iCLK) begin
        exp_t e;
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("out", out, e.out);
                chk("tick", tick, e.tick);
                chk("pending", pending, e.pending);
            end
        end
    end

    task automatic step(input bit release_rst);
        @(negedge iCLK);
        if (release_rst) begin
            iRST_N = 1'b1;
            model_reset();
        end
        en = s_en; mode = s_mode; sync = s_sync;
        wr_en = s_wr_en; wr_ch = s_wr_ch; wr_div = s_wr_div;
        mon_en = 1;
        model_step_and_push();
        s_sync = 1'b0;
        s_wr_en = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic write_div(input int ch, input int d);
        s_wr_en = 1'b1;
        s_wr_ch = 2'(ch);
        s_wr_div = CW'(d);
        step(1'b0);
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_out"}, out, '0);
        chk({tag, "_tick"}, tick, '0);
        chk({tag, "_pending"}, pending, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check_reset_zero("reset");

        // Channel 0 toggling with the reset divisor.
        s_en = 4'b0001; s_mode = 4'b0000;
        step(1'b1);
        run(24);

        // Channel 2 in pulse mode, then retuned to D = 1.
        s_en = 4'b0101; s_mode = 4'b0100;
        run(4);
        write_div(2, 1);
        run(12);

        // Channel 1: two writes before the boundary, the last wins.
        s_en = 4'b0111;
        run(1);
        write_div(1, 7);
        write_div(1, 2);
        run(16);
        // Write repeatedly to catch one landing on a terminal cycle.
        for (int k = 0; k < 6; k++) write_div(1, 2 + (k % 2));
        run(10);

        // Channels 0 and 3 at D = 4 with offset phase, then sync.
        write_div(0, 4);
        run(3);
        s_en = 4'b1111; s_mode = 4'b1001;
        write_div(3, 4);
        run(11);
        s_sync = 1'b1;
        run(16);

        // Disable channel 0 for 10 cycles, re-enable.
        s_en = 4'b1110;
        run(10);
        s_en = 4'b1111;
        run(14);

        // D = 0 toggle mode, then asynchronous reset mid-period.
        s_mode = 4'b0000;
        write_div(0, 0);
        run(9);
        @(posedge iCLK);
        #3;
        iRST_N = 1'b0;
        #1;
        check_reset_zero("async_reset");
        mon_en = 0;
        repeat (2) @(posedge iCLK);
        s_en = 4'b1111;
        step(1'b1);
        run(10);

        // Randomised traffic with short divisors.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) < 3) s_en[$urandom_range(NCH-1)] ^= 1'b1;
            if ($urandom_range(99) < 3) s_mode[$urandom_range(NCH-1)] ^= 1'b1;
            if ($urandom_range(99) < 2) s_sync = 1'b1;
            if ($urandom_range(99) < 8) begin
                s_wr_en = 1'b1;
                s_wr_ch = 2'($urandom_range(NCH-1));
                s_wr_div = CW'($urandom_range(5));
            end
            step(1'b0);
        end

        @(posedge iCLK);
        #3;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d leftover expectations, required 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
